// File: rtl/lookup_cfg_ctrl.sv
// lookup_cfg_ctrl: quiesces one lookup stage, writes a TCAM and/or action-RAM entry, then releases traffic
module lookup_cfg_ctrl #(
    parameter int STAGE     = 0,
    parameter int DATA_W    = 1024,
    parameter int ADDR_W    = 4,
    parameter int ACT_W     = 25,
    parameter int DRAIN_CYC = 4,
    parameter int BUSY_TMO  = 64
) (
    input  logic              axis_clk,
    input  logic              areset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_stage,
    input  logic [1:0]        cfg_op,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_key,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic [ACT_W-1:0]  cfg_action,
    output logic              cfg_done,
    output logic              cfg_err,
    input  logic              key_valid_in,
    output logic              key_valid_out,
    output logic              lkp_stall,
    input  logic              tcam_busy,
    output logic [DATA_W-1:0] lookup_din,
    output logic [DATA_W-1:0] lookup_din_mask,
    output logic [ADDR_W-1:0] lookup_din_addr,
    output logic              lookup_din_en,
    output logic [ACT_W-1:0]  action_data_in,
    output logic [ADDR_W-1:0] action_addr,
    output logic              action_en
);
    localparam int DC_W = $clog2(DRAIN_CYC + 1);
    localparam int BC_W = $clog2(BUSY_TMO + 1);

    typedef enum logic [2:0] {IDLE, DRAIN, TWR, TWAIT, AWR, DONE, ERR} state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] mask_q;
    logic [ACT_W-1:0]  act_q;
    logic [DC_W-1:0]   drain_cnt;
    logic [BC_W-1:0]   busy_cnt;
    logic              drain_last;
    logic              tcam_go;

    assign key_valid_out = key_valid_in & ~lkp_stall;
    assign drain_last    = state == DRAIN && drain_cnt == DC_W'(1);
    // The TCAM write is issued on the first edge where the TCAM is idle, including the last drain edge
    assign tcam_go       = ~tcam_busy & (state == TWR | (drain_last & ~op_q[0]));

    // TCAM write port: data/addr hold their last written value, enable is a single-cycle pulse
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            lookup_din_en   <= 1'b0;
        end else begin
            lookup_din_en <= tcam_go;
            if (tcam_go) begin
                lookup_din      <= key_q;
                lookup_din_mask <= mask_q;
                lookup_din_addr <= addr_q;
            end
        end
    end

    // Command sequencer: accept, drain, TCAM write and busy wait, action write, done/err
    always_ff @(posedge axis_clk) begin
        if (areset) begin
            state          <= IDLE;
            cfg_ready      <= 1'b1;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            lkp_stall      <= 1'b0;
            action_en      <= 1'b0;
            action_data_in <= '0;
            action_addr    <= '0;
            op_q           <= '0;
            addr_q         <= '0;
            key_q          <= '0;
            mask_q         <= '0;
            act_q          <= '0;
            drain_cnt      <= '0;
            busy_cnt       <= '0;
        end else begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            action_en <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
                    op_q      <= cfg_op;
                    addr_q    <= cfg_addr;
                    key_q     <= cfg_key;
                    mask_q    <= cfg_mask;
                    act_q     <= cfg_action;
                    cfg_ready <= 1'b0;
                    if (cfg_stage != 3'(STAGE)) begin
                        state    <= DONE;
                        cfg_done <= 1'b1;
                    end else if (cfg_op == 2'b11) begin
                        state   <= ERR;
                        cfg_err <= 1'b1;
                    end else begin
                        state     <= DRAIN;
                        lkp_stall <= 1'b1;
                        drain_cnt <= DC_W'(DRAIN_CYC);
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DC_W'(1);
                    busy_cnt  <= '0;
                    if (drain_last)
                        state <= op_q[0] ? AWR : tcam_go ? TWAIT : TWR;
                end
                TWR: begin
                    busy_cnt <= tcam_go ? '0 : busy_cnt + BC_W'(1);
                    if (tcam_go) begin
                        state <= TWAIT;
                    end else if (busy_cnt == BC_W'(BUSY_TMO - 1)) begin
                        state   <= ERR;
                        cfg_err <= 1'b1;
                    end
                end
                TWAIT: begin
                    busy_cnt <= busy_cnt + BC_W'(1);
                    if (busy_cnt != '0 && !tcam_busy) begin
                        state    <= op_q == 2'b00 ? AWR : DONE;
                        cfg_done <= op_q != 2'b00;
                    end else if (busy_cnt == BC_W'(BUSY_TMO - 1)) begin
                        state   <= ERR;
                        cfg_err <= 1'b1;
                    end
                end
                AWR: begin
                    action_en      <= 1'b1;
                    action_data_in <= act_q;
                    action_addr    <= addr_q;
                    cfg_done       <= 1'b1;
                    state          <= DONE;
                end
                default: begin
                    lkp_stall <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lookup_cfg_ctrl.sv
// tb_lookup_cfg_ctrl: directed and random commands against a cycle-level expectation of the sequencer
module tb_lookup_cfg_ctrl;
    localparam int DW  = 1024;
    localparam int AW  = 4;
    localparam int ACW = 25;
    localparam int D   = 4;
    localparam int TMO = 64;

    logic           axis_clk = 1'b0;
    logic           areset = 1'b1;
    logic           cfg_valid = 1'b0;
    logic [2:0]     cfg_stage = '0;
    logic [1:0]     cfg_op = '0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [DW-1:0]  cfg_key = '0;
    logic [DW-1:0]  cfg_mask = '0;
    logic [ACW-1:0] cfg_action = '0;
    logic           key_valid_in = 1'b0;
    logic           tcam_busy = 1'b0;
    logic           cfg_ready, cfg_done, cfg_err, key_valid_out, lkp_stall, lookup_din_en, action_en;
    logic [DW-1:0]  lookup_din, lookup_din_mask;
    logic [AW-1:0]  lookup_din_addr, action_addr;
    logic [ACW-1:0] action_data_in;

    int errors = 0;
    int checks = 0;

    lookup_cfg_ctrl #(
        .STAGE(0), .DATA_W(DW), .ADDR_W(AW), .ACT_W(ACW), .DRAIN_CYC(D), .BUSY_TMO(TMO)
    ) dut (
        .axis_clk(axis_clk), .areset(areset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stage(cfg_stage), .cfg_op(cfg_op),
        .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_mask(cfg_mask), .cfg_action(cfg_action),
        .cfg_done(cfg_done), .cfg_err(cfg_err),
        .key_valid_in(key_valid_in), .key_valid_out(key_valid_out), .lkp_stall(lkp_stall),
        .tcam_busy(tcam_busy),
        .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask), .lookup_din_addr(lookup_din_addr),
        .lookup_din_en(lookup_din_en),
        .action_data_in(action_data_in), .action_addr(action_addr), .action_en(action_en)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issue one command; the TCAM model holds busy for blen cycles after it captures a write, or forever when stuck
    task automatic do_cmd(input logic [2:0] stg, input logic [1:0] op, input logic [AW-1:0] adr,
                          input logic [DW-1:0] k, input logic [DW-1:0] m, input logic [ACW-1:0] a,
                          input int blen, input bit stuck);
        bit match, ill, tw, aw;
        int exp_done, exp_err, exp_we, exp_ae, exp_end;
        int we_cyc, ae_cyc, done_cyc, err_cyc, n_we, n_ae, n_done, n_err, bad;
        logic [DW-1:0]  wk, wm;
        logic [AW-1:0]  wa, aa;
        logic [ACW-1:0] ad;
        logic exp_stall, rdy_after;
        match = stg == 3'd0;
        ill   = op == 2'b11;
        tw    = match && !ill && op != 2'b01;
        aw    = match && !ill && op != 2'b10 && !(tw && stuck);
        exp_done = 0;
        exp_err  = 0;
        if (!match) exp_done = 1;
        else if (ill) exp_err = 1;
        else if (tw && stuck) exp_err = D + TMO + 1;
        else if (op == 2'b01) exp_done = D + 2;
        else if (op == 2'b10) exp_done = D + 3 + blen;
        else exp_done = D + 4 + blen;
        exp_we  = (tw && !stuck) ? D + 1 : 0;
        exp_ae  = aw ? exp_done : 0;
        exp_end = exp_done + exp_err;
        {we_cyc, ae_cyc, done_cyc, err_cyc, n_we, n_ae, n_done, n_err, bad} = '0;
        {wk, wm, wa, aa, ad} = '0;
        rdy_after = 1'b0;
        @(negedge axis_clk);
        chk("ready_before", DW'(cfg_ready), DW'(1));
        cfg_valid = 1'b1; cfg_stage = stg; cfg_op = op; cfg_addr = adr;
        cfg_key = k; cfg_mask = m; cfg_action = a;
        key_valid_in = 1'b1;
        tcam_busy = stuck;
        @(posedge axis_clk);
        for (int n = 1; n <= exp_end + 2; n++) begin
            @(negedge axis_clk);
            if (n == 1) begin
                cfg_valid = 1'b0; cfg_stage = 3'($urandom); cfg_op = 2'($urandom);
                cfg_addr = AW'($urandom); cfg_key = rnd_wide(); cfg_mask = rnd_wide();
                cfg_action = ACW'($urandom);
            end
            exp_stall = match && !ill && n <= exp_end;
            if (lkp_stall !== exp_stall || key_valid_out !== (key_valid_in & ~exp_stall)) bad++;
            if (lookup_din_en === 1'b1) begin
                n_we++; we_cyc = n; wk = lookup_din; wm = lookup_din_mask; wa = lookup_din_addr;
            end
            if (action_en === 1'b1) begin
                n_ae++; ae_cyc = n; ad = action_data_in; aa = action_addr;
            end
            if (cfg_done === 1'b1) begin n_done++; done_cyc = n; end
            if (cfg_err === 1'b1) begin n_err++; err_cyc = n; end
            if (n == exp_end + 1) rdy_after = cfg_ready;
            key_valid_in = 1'($urandom);
            tcam_busy = stuck || (we_cyc > 0 && n > we_cyc && n <= we_cyc + blen);
        end
        tcam_busy = 1'b0;
        chk_i("done_cycle", done_cyc, exp_done);
        chk_i("done_count", n_done, exp_done != 0 ? 1 : 0);
        chk_i("err_cycle", err_cyc, exp_err);
        chk_i("err_count", n_err, exp_err != 0 ? 1 : 0);
        chk_i("tcam_we_cycle", we_cyc, exp_we);
        chk_i("tcam_we_count", n_we, exp_we != 0 ? 1 : 0);
        chk_i("act_we_cycle", ae_cyc, exp_ae);
        chk_i("act_we_count", n_ae, exp_ae != 0 ? 1 : 0);
        chk_i("stall_kvo_bad_cycles", bad, 0);
        chk("ready_after", DW'(rdy_after), DW'(1));
        if (exp_we != 0) begin
            chk("tcam_key", wk, k);
            chk("tcam_mask", wm, m);
            chk("tcam_addr", DW'(wa), DW'(adr));
            chk("tcam_key_hold", lookup_din, k);
        end
        if (exp_ae != 0) begin
            chk("act_data", DW'(ad), DW'(a));
            chk("act_addr", DW'(aa), DW'(adr));
        end
    endtask

    initial begin
        int nd;
        logic [1:0] rop;
        logic [2:0] rstg;
        key_valid_in = 1'b1;
        repeat (3) @(negedge axis_clk);
        chk("rst_ready", DW'(cfg_ready), DW'(1));
        chk("rst_stall", DW'(lkp_stall), DW'(0));
        chk("rst_kvo", DW'(key_valid_out), DW'(1));
        chk("rst_done_err", DW'({cfg_done, cfg_err}), DW'(0));
        chk("rst_we", DW'({lookup_din_en, action_en}), DW'(0));
        chk("rst_din", lookup_din, '0);
        areset = 1'b0;

        do_cmd(3'd0, 2'b00, 4'd5, {128{8'hAB}}, rnd_wide(), 25'h1ABCDE, 16, 1'b0);
        do_cmd(3'd2, 2'b00, 4'd3, rnd_wide(), rnd_wide(), 25'h0155AA, 4, 1'b0);
        do_cmd(3'd0, 2'b11, 4'd7, rnd_wide(), rnd_wide(), 25'h000123, 0, 1'b0);
        do_cmd(3'd0, 2'b10, 4'd9, rnd_wide(), rnd_wide(), 25'h1FFFFF, 0, 1'b1);
        do_cmd(3'd0, 2'b10, 4'd15, rnd_wide(), rnd_wide(), 25'h000001, 0, 1'b0);
        do_cmd(3'd0, 2'b01, 4'd0, rnd_wide(), rnd_wide(), 25'h0ACE01, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rstg = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rop  = 2'($urandom);
            do_cmd(rstg, rop, AW'($urandom), rnd_wide(), rnd_wide(), ACW'($urandom),
                   int'($urandom_range(0, 20)), 1'b0);
        end

        // Reset while waiting on TCAM busy after the write
        @(negedge axis_clk);
        cfg_valid = 1'b1; cfg_stage = 3'd0; cfg_op = 2'b00; cfg_addr = 4'd9;
        cfg_key = rnd_wide(); cfg_mask = rnd_wide(); cfg_action = 25'h012345;
        key_valid_in = 1'b1;
        @(posedge axis_clk);
        for (int n = 1; n <= D + 3; n++) begin
            @(negedge axis_clk);
            cfg_valid = 1'b0;
            tcam_busy = n >= D + 2;
        end
        areset = 1'b1;
        @(negedge axis_clk);
        chk("midrst_ready", DW'(cfg_ready), DW'(1));
        chk("midrst_stall", DW'(lkp_stall), DW'(0));
        chk("midrst_done_err", DW'({cfg_done, cfg_err}), DW'(0));
        chk("midrst_we", DW'({lookup_din_en, action_en}), DW'(0));
        chk("midrst_din", lookup_din, '0);
        areset = 1'b0;
        tcam_busy = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge axis_clk);
            if (cfg_done === 1'b1 || cfg_err === 1'b1 || action_en === 1'b1) nd++;
        end
        chk_i("midrst_no_completion", nd, 0);
        do_cmd(3'd0, 2'b01, 4'd6, rnd_wide(), rnd_wide(), 25'h1C0FFE, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
